// File: rtl/audio_pkg.sv
// Shared types and constants for the audio block's sound-side logic.
package audio_pkg;

  localparam int NUM_CH = 4;

  typedef logic [2:0] step_t;

  // Bit s set means the tick fires when step s completes.
  localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
  localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

  localparam logic [2:0] NR52_UNUSED = 3'b111;

endpackage

// File: rtl/frame_prescaler.sv
// Free-running divide-by-PRESCALE counter with enable and synchronous clear.
// tc is high during the cycle the count holds PRESCALE-1 while enabled.
module frame_prescaler #(
  parameter int PRESCALE = 32768,
  localparam int PS_W = $clog2(PRESCALE)
) (
  input  logic clock,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + PS_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: step counter, length/sweep/envelope strobes and NR52 status.
// Optional FRAME_SEQ_TEST_STEP_EN adds a test_step input that forces an immediate frame step.
module frame_sequencer
  import audio_pkg::*;
#(
  parameter int PRESCALE = 32768
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              master_en,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] length_expire,
  input  logic [NUM_CH-1:0] dac_off,
`ifdef FRAME_SEQ_TEST_STEP_EN
  input  logic              test_step,
`endif
  output logic              length_tick,
  output logic              sweep_tick,
  output logic              envelope_tick,
  output step_t             step,
  output logic [NUM_CH-1:0] ch_active,
  output logic [7:0]        nr52_rd
);

  logic master_q;
  logic step_req;
  logic ps_tc;
  logic frame_step;
  logic [NUM_CH-1:0] ch_next;

`ifdef FRAME_SEQ_TEST_STEP_EN
  assign step_req = test_step;
`else
  assign step_req = 1'b0;
`endif

  // A forced step clears the prescaler, so a coincident terminal count yields one step only.
  frame_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock (clock),
    .rst_n (rst_n),
    .en    (master_en),
    .clr   (~master_en | step_req),
    .tc    (ps_tc)
  );

  assign frame_step = master_en & (ps_tc | step_req);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      master_q      <= 1'b0;
      step          <= '0;
      length_tick   <= 1'b0;
      sweep_tick    <= 1'b0;
      envelope_tick <= 1'b0;
    end else begin
      master_q      <= master_en;
      length_tick   <= 1'b0;
      sweep_tick    <= 1'b0;
      envelope_tick <= 1'b0;
      if (!master_en) begin
        step <= '0;
      end else if (frame_step) begin
        step          <= step_t'(step + 3'd1);
        length_tick   <= LEN_STEP_MASK[step];
        sweep_tick    <= SWEEP_STEP_MASK[step];
        envelope_tick <= ENV_STEP_MASK[step];
      end else if (!master_q) begin
        step <= '0;
      end
    end
  end

  // Per-channel priority: power off, trigger, DAC off, length expiry, hold.
  always_comb begin
    ch_next = ch_active;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!master_en) begin
        ch_next[i] = 1'b0;
      end else if (trigger[i] && !dac_off[i]) begin
        ch_next[i] = 1'b1;
      end else if (dac_off[i] || length_expire[i]) begin
        ch_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ch_active <= '0;
    end else begin
      ch_active <= ch_next;
    end
  end

  assign nr52_rd = {master_en, NR52_UNUSED, ch_active};

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer with PRESCALE=4; covers FRAME_SEQ_TEST_STEP_EN when defined.
module tb_frame_sequencer;

  localparam int TB_PRESCALE = 4;

  typedef struct {
    logic [2:0] ticks;
    logic [2:0] step;
    logic [3:0] ch;
    logic [7:0] nr52;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       master_en = 1'b0;
  logic [3:0] trigger = '0;
  logic [3:0] length_expire = '0;
  logic [3:0] dac_off = '0;
  logic       length_tick, sweep_tick, envelope_tick;
  logic [2:0] step;
  logic [3:0] ch_active;
  logic [7:0] nr52_rd;
`ifdef FRAME_SEQ_TEST_STEP_EN
  logic       test_step = 1'b0;
`endif

  int passCount = 0;
  int checkCount = 0;

  exp_t sb[$];
  int   mPs = 0;
  logic [2:0] mStep = '0;
  logic [2:0] mTicks = '0;
  logic [3:0] mCh = '0;

  always #5 clock = ~clock;

  frame_sequencer #(.PRESCALE(TB_PRESCALE)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .master_en     (master_en),
    .trigger       (trigger),
    .length_expire (length_expire),
    .dac_off       (dac_off),
`ifdef FRAME_SEQ_TEST_STEP_EN
    .test_step     (test_step),
`endif
    .length_tick   (length_tick),
    .sweep_tick    (sweep_tick),
    .envelope_tick (envelope_tick),
    .step          (step),
    .ch_active     (ch_active),
    .nr52_rd       (nr52_rd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Drive one cycle of inputs, advance the reference model, push its prediction,
  // then compare the DUT against the popped prediction just after the edge.
  task automatic applyStimulus(input logic rst, input logic men, input logic [3:0] trig,
                               input logic [3:0] expire, input logic [3:0] dac, input logic tstep);
    exp_t e, got;
    logic fs;
    rst_n = rst;
    master_en = men;
    trigger = trig;
    length_expire = expire;
    dac_off = dac;
`ifdef FRAME_SEQ_TEST_STEP_EN
    test_step = tstep;
`endif
    if (!rst || !men) begin
      mPs = 0;
      mStep = '0;
      mTicks = '0;
      mCh = '0;
    end else begin
      fs = (mPs == TB_PRESCALE - 1) || tstep;
      mTicks = fs ? {mStep == 3'd7, (mStep == 3'd2) || (mStep == 3'd6), ~mStep[0]} : 3'b000;
      if (fs) begin
        mStep = mStep + 3'd1;
        mPs = 0;
      end else begin
        mPs = mPs + 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (trig[i] && !dac[i]) mCh[i] = 1'b1;
        else if (dac[i] || expire[i]) mCh[i] = 1'b0;
      end
    end
    e.ticks = mTicks;
    e.step = mStep;
    e.ch = mCh;
    e.nr52 = {men, 3'b111, mCh};
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    checkOutput("ticks", {29'd0, envelope_tick, sweep_tick, length_tick}, {29'd0, got.ticks});
    checkOutput("step", {29'd0, step}, {29'd0, got.step});
    checkOutput("ch_active", {28'd0, ch_active}, {28'd0, got.ch});
    checkOutput("nr52_rd", {24'd0, nr52_rd}, {24'd0, got.nr52});
  endtask

  task automatic idle(input logic men);
    applyStimulus(1'b1, men, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    int firstLen, lenCnt, sweepCnt, envCnt, wraps, budget;
    logic [2:0] prevStep;

    // Reset holds everything at zero even with master power requested.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("reset_nr52", {24'd0, nr52_rd}, 32'hF0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Power on and count strobes over the first 32 cycles.
    firstLen = 0; lenCnt = 0; sweepCnt = 0; envCnt = 0; wraps = 0;
    prevStep = step;
    for (int i = 1; i <= 40; i++) begin
      idle(1'b1);
      if (i <= 32) begin
        if (length_tick && firstLen == 0) firstLen = i;
        lenCnt += int'(length_tick);
        sweepCnt += int'(sweep_tick);
        envCnt += int'(envelope_tick);
        if (prevStep == 3'd7 && step == 3'd0) wraps++;
      end
      prevStep = step;
    end
    checkOutput("first_len_latency", firstLen, 4);
    checkOutput("len_count", lenCnt, 4);
    checkOutput("sweep_count", sweepCnt, 2);
    checkOutput("env_count", envCnt, 1);
    checkOutput("step_wrap", wraps, 1);

    // Drop power exactly on a terminal count at step 5.
    budget = 0;
    while (!(mPs == 3 && mStep == 3'd5) && budget < 100) begin
      idle(1'b1);
      budget++;
    end
    checkOutput("reach_ps3_step5", {31'd0, budget < 100}, 32'd1);
    idle(1'b0);
    checkOutput("off_no_tick", {29'd0, envelope_tick, sweep_tick, length_tick}, 32'd0);
    checkOutput("off_step0", {29'd0, step}, 32'd0);
    idle(1'b0);
    firstLen = 0;
    for (int i = 1; i <= 6; i++) begin
      idle(1'b1);
      if (length_tick && firstLen == 0) firstLen = i;
    end
    checkOutput("reenable_len_latency", firstLen, 4);

    // Channel status rules.
    applyStimulus(1'b1, 1'b1, 4'b0101, 4'h0, 4'h0, 1'b0);
    checkOutput("trig_0101_nr52", {24'd0, nr52_rd}, 32'hF5);
    applyStimulus(1'b1, 1'b1, 4'h0, 4'b0001, 4'h0, 1'b0);
    checkOutput("expire_0001_nr52", {24'd0, nr52_rd}, 32'hF4);
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0010, 4'h0, 1'b0);
    checkOutput("trig_beats_expire", {31'd0, ch_active[1]}, 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b1000, 4'h0, 4'b1000, 1'b0);
    checkOutput("trig_dac_off", {31'd0, ch_active[3]}, 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0100, 4'h0, 4'b0100, 1'b0);
    checkOutput("dac_off_clears", {31'd0, ch_active[2]}, 32'd0);
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("all_active", {28'd0, ch_active}, 32'hF);
    idle(1'b1);
    checkOutput("hold", {28'd0, ch_active}, 32'hF);
    idle(1'b0);
    checkOutput("off_nr52", {24'd0, nr52_rd}, 32'h70);
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    checkOutput("off_trig_ignored", {28'd0, ch_active}, 32'h0);

    // Reset in the middle of activity.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("midrun_reset_ch", {28'd0, ch_active}, 32'h0);

`ifdef FRAME_SEQ_TEST_STEP_EN
    // Forced step at step 6, prescaler 1, then a forced step coinciding with terminal count.
    budget = 0;
    while (!(mPs == 1 && mStep == 3'd6) && budget < 100) begin
      idle(1'b1);
      budget++;
    end
    checkOutput("reach_ps1_step6", {31'd0, budget < 100}, 32'd1);
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("tstep_step", {29'd0, step}, 32'd7);
    checkOutput("tstep_ticks", {29'd0, envelope_tick, sweep_tick, length_tick}, 32'b011);
    for (int i = 0; i < 3; i++) idle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("tstep_coincident", {29'd0, step}, 32'd0);
    for (int i = 0; i < 10; i++) idle(1'b1);
`endif

    // Random traffic checked against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 15) != 0,
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
`ifdef FRAME_SEQ_TEST_STEP_EN
                    $urandom_range(0, 9) == 0
`else
                    1'b0
`endif
                    );
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
